dp_audio_sdp_inserter: RTL and testbench

DP_AUDIO_SDP_INSERTER -- requirements
Module: dp_audio_sdp_inserter

---
 rtl/dp_audio_sdp_inserter.sv | 234 +++++++++++++++++++++++
 tb/tb_dp_audio_sdp_inserter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dp_audio_sdp_inserter.sv
// DisplayPort audio secondary-data-packet inserter.
// Buffers audio sample frames in a small FIFO and, when a marker symbol shows
// up on lane 0 of the main-link stream, replaces lane 0 with an audio SDP
// (header, IEC-60958-style subframes with check bytes, end symbol).
// Lanes 1..3 always pass through with one cycle of latency.
module dp_audio_sdp_inserter #(
    parameter int NUM_CH     = 2,
    parameter int SAMPLE_W   = 16,
    parameter int SPP        = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       sample_valid,
    output logic                       sample_ready,
    input  logic [NUM_CH*SAMPLE_W-1:0] sample_data,
    input  logic [71:0]                in_data,
    output logic [71:0]                out_data,
    output logic [15:0]                underrun_cnt,
    output logic                       overflow
);

    localparam int FRAME_W   = NUM_CH * SAMPLE_W;
    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int NUM_GRP   = NUM_CH * SPP;
    localparam int NUM_SYM   = 10 + 5 * NUM_GRP + (NUM_GRP % 2);
    localparam int PKT_CYC   = NUM_SYM / 2;
    localparam int SYM_AW    = $clog2(NUM_SYM);
    localparam int SYM_SLOTS = 1 << SYM_AW;
    localparam int CYC_W     = SYM_AW - 1;

    localparam logic [8:0] MARKER = 9'h155;
    localparam logic [8:0] SYM_SS = 9'h15C;
    localparam logic [8:0] SYM_SE = 9'h1FD;

    // Reject parameter combinations the packet format cannot represent.
    if (NUM_CH < 2 || NUM_CH > 8 || (NUM_CH % 2) != 0) begin : g_bad_num_ch
        $error("NUM_CH must be even and within 2..8");
    end
    if (SAMPLE_W < 16 || SAMPLE_W > 24) begin : g_bad_sample_w
        $error("SAMPLE_W must be within 16..24");
    end
    if (SPP != 1 && SPP != 2) begin : g_bad_spp
        $error("SPP must be 1 or 2");
    end
    if (FIFO_DEPTH < 4 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two within 4..16");
    end

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CYC_W-1:0]   cyc;
    logic [CYC_W-1:0]   cyc_next;
    logic [17:0]        lane0_next;
    logic               pop;
    logic               push;
    logic               underrun_hit;
    logic               has_pkt;

    logic [FRAME_W-1:0] mem [0:FIFO_DEPTH-1];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;
    logic [AW:0]        count_next;

    logic [FRAME_W-1:0] pkt_buf [0:SPP-1];
    logic [8:0]         pkt_sym [0:SYM_SLOTS-1];

    // Subframe: sample left-justified into a 24-bit field at [27:4],
    // reserved bits zero, bit 31 makes the whole word even parity.
    function automatic logic [31:0] subframe(input logic [SAMPLE_W-1:0] s);
        logic [31:0] sf;
        sf = '0;
        sf[27 -: SAMPLE_W] = s;
        sf[31] = ^sf[30:0];
        return sf;
    endfunction

    assign sample_ready = !rst && (count != (AW+1)'(FIFO_DEPTH));
    assign push         = sample_valid && sample_ready;
    assign has_pkt      = count >= (AW+1)'(SPP);

    // Occupancy bookkeeping; a simultaneous push and pop both take effect.
    always_comb begin
        count_next = count;
        if (push) begin
            count_next = count_next + (AW+1)'(1);
        end
        if (pop) begin
            count_next = count_next - (AW+1)'(SPP);
        end
    end

    // Flatten the whole packet into a symbol table indexed by symbol number.
    always_comb begin
        logic [31:0] sf;
        sf = '0;
        for (int i = 0; i < SYM_SLOTS; i++) begin
            pkt_sym[i] = 9'h000;
        end
        pkt_sym[0] = SYM_SS;
        pkt_sym[1] = 9'h055;
        pkt_sym[2] = 9'h07E;
        pkt_sym[3] = 9'h005;
        pkt_sym[4] = 9'h0C7;
        pkt_sym[5] = 9'h001;
        pkt_sym[6] = 9'h007;
        pkt_sym[7] = 9'h000;
        pkt_sym[8] = 9'h060;
        for (int f = 0; f < SPP; f++) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                sf = subframe(pkt_buf[f][ch*SAMPLE_W +: SAMPLE_W]);
                for (int b = 0; b < 4; b++) begin
                    pkt_sym[9 + 5*(f*NUM_CH + ch) + b] = {1'b0, sf[8*b +: 8]};
                end
                pkt_sym[9 + 5*(f*NUM_CH + ch) + 4] =
                    {1'b0, sf[7:0] ^ sf[15:8] ^ sf[23:16] ^ sf[31:24]};
            end
        end
        pkt_sym[NUM_SYM-1] = SYM_SE;
    end

    // Next-state and lane-0 symbol selection for the insertion FSM.
    always_comb begin
        state_next   = state;
        cyc_next     = cyc;
        lane0_next   = in_data[17:0];
        pop          = 1'b0;
        underrun_hit = 1'b0;
        case (state)
            IDLE: begin
                if (in_data[8:0] == MARKER && enable) begin
                    if (has_pkt) begin
                        pop        = 1'b1;
                        state_next = SEND;
                        cyc_next   = CYC_W'(1);
                        lane0_next = {pkt_sym[1], pkt_sym[0]};
                    end else begin
                        underrun_hit     = 1'b1;
                        lane0_next[8:0]  = 9'h000;
                    end
                end
            end
            SEND: begin
                lane0_next = {pkt_sym[{cyc, 1'b1}], pkt_sym[{cyc, 1'b0}]};
                if (cyc == CYC_W'(PKT_CYC - 1)) begin
                    state_next = IDLE;
                    cyc_next   = '0;
                end else begin
                    cyc_next = cyc + CYC_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cyc_next   = '0;
            end
        endcase
    end

    // FSM state register and packet cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cyc   <= '0;
        end else begin
            state <= state_next;
            cyc   <= cyc_next;
        end
    end

    // Registered output stream; reset clears it so an aborted packet leaves nothing behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
        end else begin
            out_data <= {in_data[71:18], lane0_next};
        end
    end

    // FIFO storage; only written at the free slot, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= sample_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(SPP);
            end
            count <= count_next;
        end
    end

    // Capture the frames of a packet at the marker so the FIFO can keep filling.
    always_ff @(posedge clk) begin
        if (pop) begin
            for (int f = 0; f < SPP; f++) begin
                pkt_buf[f] <= mem[rd_ptr + AW'(f)];
            end
        end
    end

    // Status: saturating underrun counter and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_cnt <= '0;
            overflow     <= 1'b0;
        end else begin
            if (underrun_hit && underrun_cnt != 16'hFFFF) begin
                underrun_cnt <= underrun_cnt + 16'd1;
            end
            if (sample_valid && !sample_ready) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dp_audio_sdp_inserter.sv
// Directed testbench for dp_audio_sdp_inserter: default build plus an SPP=1
// build sharing the same stimulus, checked against hand-computed symbols.
module tb_dp_audio_sdp_inserter;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        sample_valid;
    logic [31:0] sample_data;
    logic [71:0] in_data;

    logic        sample_ready;
    logic [71:0] out_data;
    logic [15:0] underrun_cnt;
    logic        overflow;

    logic        ready_s1;
    logic [71:0] out_s1;
    logic [15:0] underrun_s1;
    logic        overflow_s1;

    int assert_count = 0;
    int fail_count   = 0;

    logic [8:0] exp_sym [0:29];

    always #5 clk = ~clk;

    dp_audio_sdp_inserter dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample_data  (sample_data),
        .in_data      (in_data),
        .out_data     (out_data),
        .underrun_cnt (underrun_cnt),
        .overflow     (overflow)
    );

    dp_audio_sdp_inserter #(.NUM_CH(2), .SAMPLE_W(16), .SPP(1), .FIFO_DEPTH(8)) dut_s1 (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .sample_valid (sample_valid),
        .sample_ready (ready_s1),
        .sample_data  (sample_data),
        .in_data      (in_data),
        .out_data     (out_s1),
        .underrun_cnt (underrun_s1),
        .overflow     (overflow_s1)
    );

    task automatic checkOutput(input string tag, input logic [71:0] actual, input logic [71:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Random stream word whose lane-0 symbol 0 is never the marker.
    function automatic logic [71:0] filler();
        logic [71:0] v;
        v[31:0]  = $urandom;
        v[63:32] = $urandom;
        v[71:64] = 8'($urandom);
        if (v[8:0] == 9'h155) v[0] = 1'b0;
        return v;
    endfunction

    // SPP=1 packet: the first 19 symbols match the default packet, then SE.
    function automatic logic [8:0] s1Sym(input int idx);
        return (idx == 19) ? 9'h1FD : exp_sym[idx];
    endfunction

    task automatic applyStimulus(input logic [71:0] din, input logic valid, input logic [31:0] data);
        in_data      = din;
        sample_valid = valid;
        sample_data  = data;
        tick();
    endtask

    task automatic resetDut();
        rst          = 1'b1;
        enable       = 1'b0;
        applyStimulus(filler(), 1'b0, 32'h0);
        applyStimulus(filler(), 1'b0, 32'h0);
        checkOutput("reset out_data", out_data, 72'h0);
        checkOutput("reset sample_ready", 72'(sample_ready), 72'h0);
        checkOutput("reset underrun_cnt", 72'(underrun_cnt), 72'h0);
        checkOutput("reset overflow", 72'(overflow), 72'h0);
        rst = 1'b0;
        applyStimulus(filler(), 1'b0, 32'h0);
        checkOutput("ready after reset", 72'(sample_ready), 72'h1);
    endtask

    // Drive a 16-cycle window starting with a marker and check the default packet.
    task automatic runPacket(input string name, input logic check_s1);
        logic [71:0] din;
        logic [71:0] exp;
        for (int k = 0; k < 16; k++) begin
            din = filler();
            if (k == 0 || k == 2) din[8:0] = 9'h155;
            applyStimulus(din, 1'b0, 32'h0);
            if (k < 15) exp = {din[71:18], exp_sym[2*k+1], exp_sym[2*k]};
            else        exp = din;
            checkOutput($sformatf("%s cycle %0d", name, k), out_data, exp);
            if (check_s1) begin
                if (k < 10) exp = {din[71:18], s1Sym(2*k+1), s1Sym(2*k)};
                else        exp = din;
                checkOutput($sformatf("%s spp1 cycle %0d", name, k), out_s1, exp);
            end
        end
    endtask

    initial begin
        logic [71:0] din;

        exp_sym = '{9'h15C, 9'h055, 9'h07E, 9'h005, 9'h0C7, 9'h001, 9'h007, 9'h000, 9'h060,
                    9'h000, 9'h040, 9'h023, 9'h081, 9'h0E2,
                    9'h000, 9'h0D0, 9'h0BC, 9'h00A, 9'h066,
                    9'h000, 9'h010, 9'h000, 9'h080, 9'h090,
                    9'h000, 9'h000, 9'h000, 9'h088, 9'h088,
                    9'h1FD};
        rst          = 1'b1;
        enable       = 1'b0;
        sample_valid = 1'b0;
        sample_data  = 32'h0;
        in_data      = 72'h0;

        // Two frames then a marker: full packet, and 10-cycle packet for SPP=1.
        resetDut();
        applyStimulus(filler(), 1'b1, 32'hABCD_1234);
        applyStimulus(filler(), 1'b1, 32'h8000_0001);
        enable = 1'b1;
        runPacket("basic pkt", 1'b1);
        checkOutput("basic underrun_cnt", 72'(underrun_cnt), 72'h0);
        checkOutput("basic spp1 underrun_cnt", 72'(underrun_s1), 72'h0);

        // Empty FIFO: markers are blanked and counted; disabled markers pass.
        resetDut();
        enable = 1'b1;
        din = filler();
        din[8:0] = 9'h155;
        applyStimulus(din, 1'b0, 32'h0);
        checkOutput("underrun blank", out_data, {din[71:9], 9'h000});
        checkOutput("underrun count 1", 72'(underrun_cnt), 72'h1);
        din = filler();
        applyStimulus(din, 1'b0, 32'h0);
        checkOutput("underrun passthru", out_data, din);
        din = filler();
        din[8:0] = 9'h155;
        applyStimulus(din, 1'b0, 32'h0);
        checkOutput("underrun count 2", 72'(underrun_cnt), 72'h2);
        enable = 1'b0;
        din = filler();
        din[8:0] = 9'h155;
        applyStimulus(din, 1'b0, 32'h0);
        checkOutput("disabled marker passthru", out_data, din);
        checkOutput("disabled underrun held", 72'(underrun_cnt), 72'h2);

        // Fill to full, overrun by three, then a disabled and an enabled marker.
        resetDut();
        for (int i = 0; i < 11; i++) begin
            applyStimulus(filler(), 1'b1,
                          (i == 0) ? 32'hABCD_1234 : (i == 1) ? 32'h8000_0001 : $urandom);
            if (i == 7) begin
                checkOutput("full ready", 72'(sample_ready), 72'h0);
                checkOutput("full no overflow yet", 72'(overflow), 72'h0);
            end
        end
        sample_valid = 1'b0;
        checkOutput("overrun ready", 72'(sample_ready), 72'h0);
        checkOutput("overrun overflow", 72'(overflow), 72'h1);
        checkOutput("overrun spp1 overflow", 72'(overflow_s1), 72'h1);
        din = filler();
        din[8:0] = 9'h155;
        applyStimulus(din, 1'b0, 32'h0);
        checkOutput("full disabled marker", out_data, din);
        checkOutput("full disabled ready", 72'(sample_ready), 72'h0);
        enable = 1'b1;
        din = filler();
        din[8:0] = 9'h155;
        applyStimulus(din, 1'b0, 32'h0);
        checkOutput("full pkt cycle 0", out_data, {din[71:18], exp_sym[1], exp_sym[0]});
        checkOutput("ready after pop", 72'(sample_ready), 72'h1);
        checkOutput("spp1 ready after pop", 72'(ready_s1), 72'h1);
        for (int k = 1; k < 15; k++) begin
            din = filler();
            applyStimulus(din, 1'b0, 32'h0);
            checkOutput($sformatf("full pkt cycle %0d", k), out_data,
                        {din[71:18], exp_sym[2*k+1], exp_sym[2*k]});
        end
        checkOutput("overflow sticky", 72'(overflow), 72'h1);

        // Reset two cycles into a packet: output clears, then pure pass-through.
        resetDut();
        applyStimulus(filler(), 1'b1, 32'hABCD_1234);
        applyStimulus(filler(), 1'b1, 32'h8000_0001);
        enable = 1'b1;
        for (int k = 0; k < 2; k++) begin
            din = filler();
            if (k == 0) din[8:0] = 9'h155;
            applyStimulus(din, 1'b0, 32'h0);
            checkOutput($sformatf("abort pkt cycle %0d", k), out_data,
                        {din[71:18], exp_sym[2*k+1], exp_sym[2*k]});
        end
        rst = 1'b1;
        applyStimulus(filler(), 1'b0, 32'h0);
        checkOutput("abort out_data", out_data, 72'h0);
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            din = filler();
            applyStimulus(din, 1'b0, 32'h0);
            checkOutput($sformatf("abort passthru %0d", k), out_data, din);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
